// File: rtl/ped_request_unit.sv
// Pedestrian push-button front end: synchronise and debounce btn_raw, turn a press into a
// request held until ped_ack, then block new requests for a fixed lockout period.
module ped_request_unit #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned LOCKOUT_CYCLES  = 30,
  parameter int unsigned BLINK_HALF      = 2
) (
  input  logic clk_out,
  input  logic reset,
  input  logic btn_raw,
  input  logic ped_ack,
  output logic ped_req,
  output logic wait_lamp,
  output logic btn_clean,
  output logic lockout
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned LW = $clog2(LOCKOUT_CYCLES + 1);
  localparam int unsigned BW = $clog2(BLINK_HALF + 1);
  localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [LW-1:0] LOCK_LAST  = LW'(LOCKOUT_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    LOCKOUT = 2'd2
  } state_t;

  logic          sync1, sync2;
  logic [DW-1:0] db_cnt;
  logic          clean_d;
  logic          press;

  state_t        state, state_n;
  logic [LW-1:0] lock_cnt, lock_cnt_n;
  logic [BW-1:0] blink_cnt, blink_cnt_n;
  logic          lamp_n;

  // Synchroniser and debounce: btn_clean only follows the synchronised level after
  // DEBOUNCE_CYCLES consecutive mismatching samples.
  always_ff @(posedge clk_out or posedge reset) begin
    if (reset) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      db_cnt    <= '0;
      btn_clean <= 1'b0;
      clean_d   <= 1'b0;
    end else begin
      sync1   <= btn_raw;
      sync2   <= sync1;
      clean_d <= btn_clean;
      if (sync2 == btn_clean) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        btn_clean <= sync2;
        db_cnt    <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  assign press = btn_clean & ~clean_d;

  always_ff @(posedge clk_out or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      lock_cnt  <= '0;
      blink_cnt <= '0;
      wait_lamp <= 1'b0;
    end else begin
      state     <= state_n;
      lock_cnt  <= lock_cnt_n;
      blink_cnt <= blink_cnt_n;
      wait_lamp <= lamp_n;
    end
  end

  always_comb begin
    state_n     = state;
    lock_cnt_n  = lock_cnt;
    blink_cnt_n = blink_cnt;
    lamp_n      = 1'b0;
    case (state)
      IDLE: begin
        if (press) begin
          state_n     = REQ;
          blink_cnt_n = '0;
          lamp_n      = 1'b1;
        end
      end
      REQ: begin
        if (ped_ack) begin
          state_n    = LOCKOUT;
          lock_cnt_n = '0;
        end else if (blink_cnt == BLINK_LAST) begin
          blink_cnt_n = '0;
          lamp_n      = ~wait_lamp;
        end else begin
          blink_cnt_n = blink_cnt + 1'b1;
          lamp_n      = wait_lamp;
        end
      end
      LOCKOUT: begin
        if (lock_cnt == LOCK_LAST) begin
          state_n    = IDLE;
          lock_cnt_n = '0;
        end else begin
          lock_cnt_n = lock_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign ped_req = (state == REQ);
  assign lockout = (state == LOCKOUT);

endmodule

// File: tb/tb_ped_request_unit.sv
// Directed bench for ped_request_unit with default parameters: a per-edge vector table
// for the first press, plus hand sequences for handshake, lockout, reset and bounce.
module tb_ped_request_unit;

  logic clk_out = 1'b0;
  logic reset   = 1'b1;
  logic btn_raw = 1'b0;
  logic ped_ack = 1'b0;
  logic ped_req, wait_lamp, btn_clean, lockout;

  int checks   = 0;
  int failures = 0;

  ped_request_unit #(
    .DEBOUNCE_CYCLES(4),
    .LOCKOUT_CYCLES (30),
    .BLINK_HALF     (2)
  ) dut (
    .clk_out  (clk_out),
    .reset    (reset),
    .btn_raw  (btn_raw),
    .ped_ack  (ped_ack),
    .ped_req  (ped_req),
    .wait_lamp(wait_lamp),
    .btn_clean(btn_clean),
    .lockout  (lockout)
  );

  always #5 clk_out = ~clk_out;

  typedef struct packed {
    logic btn;
    logic ack;
    logic req;
    logic lamp;
    logic clean;
    logic lock;
  } vec_t;

  vec_t tbl[12];

  function automatic vec_t mk(input logic b, a, r, l, c, k);
    vec_t v;
    v.btn = b; v.ack = a; v.req = r; v.lamp = l; v.clean = c; v.lock = k;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_out);
    @(negedge clk_out);
  endtask

  initial begin
    int   n, clean_at, req_at, lock_cycles;
    logic bad;

    // Row i: inputs applied before edge E(i+1), outputs expected after it.
    for (int i = 0; i < 5; i++) tbl[i] = mk(1, 0, 0, 0, 0, 0);
    tbl[5]  = mk(1, 0, 0, 0, 1, 0);
    tbl[6]  = mk(1, 1, 1, 1, 1, 0);  // ack coincides with press event: ignored in IDLE
    tbl[7]  = mk(1, 0, 1, 1, 1, 0);
    tbl[8]  = mk(1, 0, 1, 0, 1, 0);
    tbl[9]  = mk(1, 0, 1, 0, 1, 0);
    tbl[10] = mk(1, 0, 1, 1, 1, 0);
    tbl[11] = mk(1, 0, 1, 1, 1, 0);

    // Reset state
    @(negedge clk_out);
    @(negedge clk_out);
    check("rst_req", ped_req, 0);
    check("rst_lamp", wait_lamp, 0);
    check("rst_clean", btn_clean, 0);
    check("rst_lock", lockout, 0);
    reset = 1'b0;

    // Clean press with simultaneous ack on the press-event cycle
    for (int i = 0; i < 12; i++) begin
      btn_raw = tbl[i].btn;
      ped_ack = tbl[i].ack;
      step();
      check($sformatf("v%0d_req", i + 1), ped_req, tbl[i].req);
      check($sformatf("v%0d_lamp", i + 1), wait_lamp, tbl[i].lamp);
      check($sformatf("v%0d_clean", i + 1), btn_clean, tbl[i].clean);
      check($sformatf("v%0d_lock", i + 1), lockout, tbl[i].lock);
    end
    ped_ack = 1'b0;

    // Release then press again while in REQ: no state change
    bad = 1'b0;
    btn_raw = 1'b0;
    for (int i = 0; i < 8; i++) begin step(); if (!ped_req || lockout) bad = 1'b1; end
    btn_raw = 1'b1;
    for (int i = 0; i < 8; i++) begin step(); if (!ped_req || lockout) bad = 1'b1; end
    check("req_extra_press_hold", bad, 0);

    // Handshake: one-cycle ack, release button
    ped_ack = 1'b1;
    step();
    ped_ack = 1'b0;
    btn_raw = 1'b0;
    check("ack_req", ped_req, 0);
    check("ack_lamp", wait_lamp, 0);
    check("ack_lock", lockout, 1);

    // Lockout length, with a press made and held mid-lockout
    lock_cycles = 1;
    bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i == 8) btn_raw = 1'b1;
      step();
      if (ped_req || wait_lamp) bad = 1'b1;
      if (lockout) lock_cycles++;
      else break;
    end
    check("lock_len", lock_cycles, 30);
    check("lock_no_req", bad, 0);
    check("lock_btn_clean_held", btn_clean, 1);
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin step(); if (ped_req || lockout) bad = 1'b1; end
    check("held_btn_no_req", bad, 0);

    // Release, then fresh press
    btn_raw = 1'b0;
    for (int i = 0; i < 10; i++) step();
    check("release_clean", btn_clean, 0);
    btn_raw = 1'b1;
    n = 0; clean_at = -1; req_at = -1;
    for (int i = 0; i < 20; i++) begin
      step();
      n++;
      if (btn_clean && clean_at < 0) clean_at = n;
      if (ped_req) begin req_at = n; break; end
    end
    check("repress_clean_edge", clean_at, 6);
    check("repress_req_edge", req_at, 7);

    // Reset mid-REQ with button held
    #2 reset = 1'b1;
    #1;
    check("midrst_req", ped_req, 0);
    check("midrst_lamp", wait_lamp, 0);
    check("midrst_clean", btn_clean, 0);
    @(negedge clk_out);
    @(negedge clk_out);
    reset = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      step();
      if (e == 6) begin
        check("postrst_e6_req", ped_req, 0);
        check("postrst_e6_clean", btn_clean, 1);
      end
      if (e == 7) check("postrst_e7_req", ped_req, 1);
    end

    // Bounce: 3 high, 1 low, five times; never long enough to debounce
    reset = 1'b1;
    btn_raw = 1'b0;
    step();
    reset = 1'b0;
    bad = 1'b0;
    for (int r = 0; r < 5; r++) begin
      btn_raw = 1'b1;
      for (int i = 0; i < 3; i++) begin step(); if (btn_clean || ped_req) bad = 1'b1; end
      btn_raw = 1'b0;
      step();
      if (btn_clean || ped_req) bad = 1'b1;
    end
    for (int i = 0; i < 8; i++) begin step(); if (btn_clean || ped_req) bad = 1'b1; end
    check("bounce_rejected", bad, 0);
    check("bounce_idle_lock", lockout, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
